// File: rtl/hash_pe_result_deserializer.sv
// hash_pe_result_deserializer
// Gathers scalar hash-PE results, each tagged with its absolute address, into
// window-aligned ISSUE_WIDTH-slot vectors with a valid mask. A window is closed
// by a window change, an offset that does not increase, the last slot, a
// delimiter, or an idle timeout. All outputs come straight from the output
// register. ISSUE_WIDTH must be a power of two, at least 2.
module hash_pe_result_deserializer #(
   parameter int ISSUE_WIDTH   = 8,
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 16,
   parameter int TIMEOUT_WIDTH = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [TIMEOUT_WIDTH-1:0]          cfg_flush_timeout,
   input  logic                              input_valid,
   input  logic [ADDR_WIDTH-1:0]             input_addr,
   input  logic [DATA_WIDTH-1:0]             input_data,
   input  logic                              input_delim,
   output logic                              input_ready,
   output logic                              output_valid,
   output logic [ADDR_WIDTH-1:0]             output_head_addr,
   output logic [ISSUE_WIDTH-1:0]            output_mask_vec,
   output logic [DATA_WIDTH*ISSUE_WIDTH-1:0] output_data_vec,
   output logic                              output_delim,
   input  logic                              output_ready
);

   localparam int              LOG2     = $clog2(ISSUE_WIDTH);
   localparam int              VEC_W    = DATA_WIDTH * ISSUE_WIDTH;
   localparam logic [LOG2-1:0] LAST_OFF = LOG2'(ISSUE_WIDTH - 1);

   // Accumulator. Mask and data are all-zero whenever acc_valid_q is low, so
   // merging a new slot into them needs no extra gating.
   // acc_closed_q marks a window that must not absorb anything more: it was
   // opened by a closing input in the same cycle the previous window split
   // out, so it waits for a free output register. acc_delim_q carries that
   // input's delimiter flag along with it.
   logic                    acc_valid_q,    acc_valid_d;
   logic [ADDR_WIDTH-1:0]   acc_base_q,     acc_base_d;
   logic [ISSUE_WIDTH-1:0]  acc_mask_q,     acc_mask_d;
   logic [VEC_W-1:0]        acc_data_q,     acc_data_d;
   logic [LOG2-1:0]         acc_last_off_q, acc_last_off_d;
   logic                    acc_closed_q,   acc_closed_d;
   logic                    acc_delim_q,    acc_delim_d;
   logic [TIMEOUT_WIDTH-1:0] idle_cnt_q,    idle_cnt_d;

   // Output register
   logic                    out_valid_q,    out_valid_d;
   logic [ADDR_WIDTH-1:0]   out_head_q,     out_head_d;
   logic [ISSUE_WIDTH-1:0]  out_mask_q,     out_mask_d;
   logic [VEC_W-1:0]        out_data_q,     out_data_d;
   logic                    out_delim_q,    out_delim_d;

   // Input decode
   logic [LOG2-1:0]         in_off;
   logic [ADDR_WIDTH-1:0]   in_base;
   logic [ISSUE_WIDTH-1:0]  slot_hit;
   logic [VEC_W-1:0]        fresh_data;
   logic [VEC_W-1:0]        merged_data;
   logic [ISSUE_WIDTH-1:0]  merged_mask;

   // Control
   logic                    space;
   logic                    absorb;
   logic                    closing;
   logic                    in_ready;
   logic                    accept;
   logic [TIMEOUT_WIDTH:0]  idle_plus1;
   logic                    timeout_hit;
   logic                    flush;

   assign in_off  = input_addr[LOG2-1:0];
   assign in_base = {input_addr[ADDR_WIDTH-1:LOG2], {LOG2{1'b0}}};

   // Per-slot steering of the incoming payload into a fresh or merged vector
   genvar gi;
   generate
      for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_slot
         assign slot_hit[gi] = (in_off == LOG2'(gi));
         assign fresh_data[gi*DATA_WIDTH +: DATA_WIDTH] =
            slot_hit[gi] ? input_data : '0;
         assign merged_data[gi*DATA_WIDTH +: DATA_WIDTH] =
            slot_hit[gi] ? input_data : acc_data_q[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   assign merged_mask = acc_mask_q | slot_hit;

   // Classify the presented input and decide acceptance and timeout flush
   always_comb begin
      space      = !out_valid_q || output_ready;
      absorb     = !acc_valid_q ||
                   (!acc_closed_q && (in_base == acc_base_q) && (in_off > acc_last_off_q));
      closing    = absorb && (input_delim || (in_off == LAST_OFF));
      // A non-closing absorb never touches the output register
      in_ready   = (!absorb || closing) ? space : 1'b1;
      accept     = input_valid && in_ready;
      idle_plus1 = {1'b0, idle_cnt_q} + {{TIMEOUT_WIDTH{1'b0}}, 1'b1};
      // The current idle cycle is the one that reaches the threshold
      timeout_hit = (cfg_flush_timeout != '0) &&
                    (idle_plus1 >= {1'b0, cfg_flush_timeout});
      flush      = acc_valid_q && !accept && space && (acc_closed_q || timeout_hit);
   end

   // Next state of accumulator, idle counter and output register
   always_comb begin
      acc_valid_d    = acc_valid_q;
      acc_base_d     = acc_base_q;
      acc_mask_d     = acc_mask_q;
      acc_data_d     = acc_data_q;
      acc_last_off_d = acc_last_off_q;
      acc_closed_d   = acc_closed_q;
      acc_delim_d    = acc_delim_q;
      out_valid_d    = out_valid_q;
      out_head_d     = out_head_q;
      out_mask_d     = out_mask_q;
      out_data_d     = out_data_q;
      out_delim_d    = out_delim_q;

      if (out_valid_q && output_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept && !absorb) begin
         // Split: current window goes out, the input opens a new one
         out_valid_d    = 1'b1;
         out_head_d     = acc_base_q;
         out_mask_d     = acc_mask_q;
         out_data_d     = acc_data_q;
         out_delim_d    = acc_delim_q;
         acc_valid_d    = 1'b1;
         acc_base_d     = in_base;
         acc_mask_d     = slot_hit;
         acc_data_d     = fresh_data;
         acc_last_off_d = in_off;
         acc_closed_d   = input_delim || (in_off == LAST_OFF);
         acc_delim_d    = input_delim;
      end else if (accept && closing) begin
         // Closing absorb: merged window bypasses the accumulator
         out_valid_d    = 1'b1;
         out_head_d     = in_base;
         out_mask_d     = merged_mask;
         out_data_d     = merged_data;
         out_delim_d    = input_delim;
         acc_valid_d    = 1'b0;
         acc_base_d     = '0;
         acc_mask_d     = '0;
         acc_data_d     = '0;
         acc_last_off_d = '0;
         acc_closed_d   = 1'b0;
         acc_delim_d    = 1'b0;
      end else if (accept) begin
         acc_valid_d    = 1'b1;
         acc_base_d     = in_base;
         acc_mask_d     = merged_mask;
         acc_data_d     = merged_data;
         acc_last_off_d = in_off;
      end else if (flush) begin
         // Idle timeout, or a closed window that was waiting for space
         out_valid_d    = 1'b1;
         out_head_d     = acc_base_q;
         out_mask_d     = acc_mask_q;
         out_data_d     = acc_data_q;
         out_delim_d    = acc_delim_q;
         acc_valid_d    = 1'b0;
         acc_base_d     = '0;
         acc_mask_d     = '0;
         acc_data_d     = '0;
         acc_last_off_d = '0;
         acc_closed_d   = 1'b0;
         acc_delim_d    = 1'b0;
      end

      if (accept || flush || !acc_valid_q) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q != '1) begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end else begin
         idle_cnt_d = idle_cnt_q;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_valid_q    <= 1'b0;
         acc_base_q     <= '0;
         acc_mask_q     <= '0;
         acc_data_q     <= '0;
         acc_last_off_q <= '0;
         acc_closed_q   <= 1'b0;
         acc_delim_q    <= 1'b0;
         idle_cnt_q     <= '0;
         out_valid_q    <= 1'b0;
         out_head_q     <= '0;
         out_mask_q     <= '0;
         out_data_q     <= '0;
         out_delim_q    <= 1'b0;
      end else begin
         acc_valid_q    <= acc_valid_d;
         acc_base_q     <= acc_base_d;
         acc_mask_q     <= acc_mask_d;
         acc_data_q     <= acc_data_d;
         acc_last_off_q <= acc_last_off_d;
         acc_closed_q   <= acc_closed_d;
         acc_delim_q    <= acc_delim_d;
         idle_cnt_q     <= idle_cnt_d;
         out_valid_q    <= out_valid_d;
         out_head_q     <= out_head_d;
         out_mask_q     <= out_mask_d;
         out_data_q     <= out_data_d;
         out_delim_q    <= out_delim_d;
      end
   end

   assign input_ready      = in_ready;
   assign output_valid     = out_valid_q;
   assign output_head_addr = out_head_q;
   assign output_mask_vec  = out_mask_q;
   assign output_data_vec  = out_data_q;
   assign output_delim     = out_delim_q;

endmodule

// File: tb/tb_hash_pe_result_deserializer.sv
// Bench for hash_pe_result_deserializer: directed scenarios followed by a
// randomized stream scored against a window-grouping reference model.
module tb_hash_pe_result_deserializer;

   logic         clk;
   logic         rst;
   logic [7:0]   cfg_flush_timeout;
   logic         input_valid;
   logic [31:0]  input_addr;
   logic [15:0]  input_data;
   logic         input_delim;
   logic         input_ready;
   logic         output_valid;
   logic [31:0]  output_head_addr;
   logic [7:0]   output_mask_vec;
   logic [127:0] output_data_vec;
   logic         output_delim;
   logic         output_ready;

   hash_pe_result_deserializer dut (
      .clk               (clk),
      .rst               (rst),
      .cfg_flush_timeout (cfg_flush_timeout),
      .input_valid       (input_valid),
      .input_addr        (input_addr),
      .input_data        (input_data),
      .input_delim       (input_delim),
      .input_ready       (input_ready),
      .output_valid      (output_valid),
      .output_head_addr  (output_head_addr),
      .output_mask_vec   (output_mask_vec),
      .output_data_vec   (output_data_vec),
      .output_delim      (output_delim),
      .output_ready      (output_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int chk_cnt  = 0;

   // Reference model: the window currently being gathered and the vectors
   // that must come out, in order
   logic         g_valid = 1'b0;
   logic [31:0]  g_base  = '0;
   logic [7:0]   g_mask  = '0;
   logic [127:0] g_data  = '0;
   int           g_last  = 0;
   logic [31:0]  exp_head[$];
   logic [7:0]   exp_mask[$];
   logic [127:0] exp_data[$];
   logic         exp_delim[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      chk_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] dat(input logic [31:0] a);
      return a[15:0] ^ 16'h5A5A;
   endfunction

   function automatic logic [127:0] sv(input int s, input logic [31:0] a);
      logic [127:0] v;
      v = '0;
      v[s*16 +: 16] = dat(a);
      return v;
   endfunction

   function automatic void model_emit(input logic d);
      exp_head.push_back(g_base);
      exp_mask.push_back(g_mask);
      exp_data.push_back(g_data);
      exp_delim.push_back(d);
      g_valid = 1'b0;
      g_mask  = '0;
      g_data  = '0;
   endfunction

   function automatic void model_accept(input logic [31:0] a, input logic [15:0] d, input logic dl);
      int off;
      logic [31:0] base;
      off  = int'(a % 8);
      base = a - 32'(off);
      if (g_valid && (base != g_base || off <= g_last)) model_emit(1'b0);
      if (!g_valid) begin
         g_valid = 1'b1;
         g_base  = base;
      end
      g_mask[off] = 1'b1;
      g_data[off*16 +: 16] = d;
      g_last = off;
      if (dl || off == 7) model_emit(dl);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one scalar and hold it until accepted
   task automatic send(input logic [31:0] a, input logic dl);
      int n;
      input_valid = 1'b1;
      input_addr  = a;
      input_data  = dat(a);
      input_delim = dl;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (input_ready) break;
      end
      chk("send_accept", 128'(input_ready), 128'(1));
      @(posedge clk);
      #1;
      input_valid = 1'b0;
      input_delim = 1'b0;
      $display("sent addr=%08h delim=%0d", a, dl);
   endtask

   task automatic chk_out(input string tag, input logic [31:0] h, input logic [7:0] m,
                          input logic [127:0] d, input logic dl);
      chk({tag, "_valid"}, 128'(output_valid), 128'(1));
      chk({tag, "_head"},  128'(output_head_addr), 128'(h));
      chk({tag, "_mask"},  128'(output_mask_vec), 128'(m));
      chk({tag, "_data"},  output_data_vec, d);
      chk({tag, "_delim"}, 128'(output_delim), 128'(dl));
      $display("%s: head=%08h mask=%02h delim=%0d", tag, output_head_addr, output_mask_vec, output_delim);
   endtask

   // Compare the vector being popped on the coming edge with the model queue
   task automatic pop_check(input string tag);
      chk({tag, "_expected"}, 128'(exp_head.size() != 0), 128'(1));
      if (exp_head.size() != 0) begin
         chk({tag, "_head"},  128'(output_head_addr), 128'(exp_head.pop_front()));
         chk({tag, "_mask"},  128'(output_mask_vec), 128'(exp_mask.pop_front()));
         chk({tag, "_data"},  output_data_vec, exp_data.pop_front());
         chk({tag, "_delim"}, 128'(output_delim), 128'(exp_delim.pop_front()));
      end
      $display("%s pop: head=%08h mask=%02h delim=%0d", tag, output_head_addr, output_mask_vec, output_delim);
   endtask

   initial begin
      logic         hold_prev;
      logic [31:0]  prev_head;
      logic [7:0]   prev_mask;
      logic [127:0] prev_data;
      logic         prev_delim;
      logic         took;
      int           issued;
      int           done_cnt;

      rst = 1'b1;
      cfg_flush_timeout = '0;
      input_valid = 1'b0;
      input_addr = '0;
      input_data = '0;
      input_delim = 1'b0;
      output_ready = 1'b1;
      repeat (3) step();

      // Reset state
      chk("rst_valid", 128'(output_valid), 128'(0));
      chk("rst_head",  128'(output_head_addr), 128'(0));
      chk("rst_mask",  128'(output_mask_vec), 128'(0));
      chk("rst_data",  output_data_vec, 128'(0));
      chk("rst_delim", 128'(output_delim), 128'(0));
      rst = 1'b0;
      step();
      chk("rst_ready", 128'(input_ready), 128'(1));

      // Window split on base change
      send(32'h100, 1'b0);
      send(32'h102, 1'b0);
      send(32'h105, 1'b0);
      send(32'h10A, 1'b0);
      chk_out("split", 32'h100, 8'h25, sv(0, 32'h100) | sv(2, 32'h102) | sv(5, 32'h105), 1'b0);
      send(32'h10B, 1'b1);
      chk_out("split_rest", 32'h108, 8'h0C, sv(2, 32'h10A) | sv(3, 32'h10B), 1'b1);

      // Last-slot close
      send(32'h207, 1'b0);
      chk_out("lastslot", 32'h200, 8'h80, sv(7, 32'h207), 1'b0);

      // Delimiter close; 0x300 must be absorbed into an empty acc
      send(32'h300, 1'b0);
      chk("delim_acc_empty", 128'(output_valid), 128'(0));
      send(32'h301, 1'b1);
      chk_out("delim", 32'h300, 8'h03, sv(0, 32'h300) | sv(1, 32'h301), 1'b1);
      step();
      chk("delim_popped", 128'(output_valid), 128'(0));

      // Backpressure
      output_ready = 1'b0;
      send(32'h100, 1'b0);
      send(32'h101, 1'b0);
      send(32'h109, 1'b0);
      chk_out("bp_setup", 32'h100, 8'h03, sv(0, 32'h100) | sv(1, 32'h101), 1'b0);
      input_valid = 1'b1;
      input_addr  = 32'h110;
      input_data  = dat(32'h110);
      input_delim = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_stall_ready", 128'(input_ready), 128'(0));
         chk("bp_hold_valid", 128'(output_valid), 128'(1));
         chk("bp_hold_head", 128'(output_head_addr), 128'(32'h100));
         chk("bp_hold_mask", 128'(output_mask_vec), 128'(8'h03));
      end
      step();
      output_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 128'(input_ready), 128'(1));
      step();
      input_valid = 1'b0;
      chk_out("bp_reload", 32'h108, 8'h02, sv(1, 32'h109), 1'b0);
      step();
      chk("bp_reload_popped", 128'(output_valid), 128'(0));
      send(32'h111, 1'b1);
      chk_out("bp_tail", 32'h110, 8'h03, sv(0, 32'h110) | sv(1, 32'h111), 1'b1);
      step();

      // Out-of-order split followed by idle timeout
      cfg_flush_timeout = 8'd4;
      send(32'h505, 1'b0);
      send(32'h503, 1'b0);
      chk_out("ooo", 32'h500, 8'h20, sv(5, 32'h505), 1'b0);
      step();
      step();
      step();
      chk("tmo_not_early", 128'(output_valid), 128'(0));
      step();
      chk_out("tmo", 32'h500, 8'h08, sv(3, 32'h503), 1'b0);
      step();
      cfg_flush_timeout = 8'd0;

      // Reset mid-fill
      send(32'h620, 1'b0);
      send(32'h621, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstmid_valid", 128'(output_valid), 128'(0));
      step();
      step();
      chk("rstmid_still_idle", 128'(output_valid), 128'(0));
      send(32'h600, 1'b1);
      chk_out("rstmid_fresh", 32'h600, 8'h01, sv(0, 32'h600), 1'b1);
      step();

      // Randomized stream against the reference model, timeout disabled
      hold_prev = 1'b0;
      prev_head = '0;
      prev_mask = '0;
      prev_data = '0;
      prev_delim = 1'b0;
      took = 1'b0;
      issued = 0;
      done_cnt = 0;
      for (int cyc = 0; cyc < 20000 && done_cnt < 400; cyc++) begin
         if (!input_valid && issued < 400 && $urandom_range(0, 4) != 0) begin
            input_valid = 1'b1;
            input_addr  = 32'h1000 + 32'($urandom_range(0, 3) * 8) + 32'($urandom_range(0, 7));
            input_data  = 16'($urandom);
            input_delim = ($urandom_range(0, 7) == 0);
            issued++;
         end
         output_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (output_valid) chk("rnd_mask_nonzero", 128'(output_mask_vec != 8'h00), 128'(1));
         if (hold_prev) begin
            chk("rnd_stable_valid", 128'(output_valid), 128'(1));
            chk("rnd_stable_head", 128'(output_head_addr), 128'(prev_head));
            chk("rnd_stable_mask", 128'(output_mask_vec), 128'(prev_mask));
            chk("rnd_stable_data", output_data_vec, prev_data);
            chk("rnd_stable_delim", 128'(output_delim), 128'(prev_delim));
         end
         hold_prev  = output_valid && !output_ready;
         prev_head  = output_head_addr;
         prev_mask  = output_mask_vec;
         prev_data  = output_data_vec;
         prev_delim = output_delim;
         if (output_valid && output_ready) pop_check("rnd");
         took = input_valid && input_ready;
         if (took) begin
            model_accept(input_addr, input_data, input_delim);
            done_cnt++;
         end
         step();
         if (took) begin
            input_valid = 1'b0;
            input_delim = 1'b0;
         end
      end
      chk("rnd_all_accepted", 128'(done_cnt), 128'(400));

      // Drain: the last partial window leaves via the timeout
      if (g_valid) model_emit(1'b0);
      cfg_flush_timeout = 8'd3;
      output_ready = 1'b1;
      for (int i = 0; i < 300 && exp_head.size() != 0; i++) begin
         @(negedge clk);
         if (output_valid) pop_check("drain");
         step();
      end
      chk("drain_queue_empty", 128'(exp_head.size()), 128'(0));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("drain_idle", 128'(output_valid), 128'(0));
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
